// File: rtl/exc_redirect_pkg.sv
// Shared types and constants for the exception/ERET fetch redirect block.
package exc_redirect_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_NORM  = 2'd1;
    localparam logic [1:0] EXC_DSLOT = 2'd2;

    localparam int unsigned FLUSH_IF  = 0;
    localparam int unsigned FLUSH_ID  = 1;
    localparam int unsigned FLUSH_EX  = 2;
    localparam int unsigned FLUSH_MEM = 3;

    localparam logic [3:0] FLUSH_MASK_EXC  = 4'b1111;
    // ERET only needs to drop the younger fetch/decode work.
    localparam logic [3:0] FLUSH_MASK_ERET = 4'(1 << FLUSH_IF) | 4'(1 << FLUSH_ID);

    localparam logic [31:0] DEFAULT_VECTOR = 32'hBFC00380;

endpackage

// File: rtl/exc_redirect.sv
// Flushes the pipeline and redirects fetch on exception entry or ERET.
// Optional exception counter enabled by defining EXC_REDIRECT_COUNT_EN.
module exc_redirect
    import exc_redirect_pkg::*;
#(
    parameter logic [31:0] VECTOR       = DEFAULT_VECTOR,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  exc,
    input  logic        back,
    input  logic [31:0] epc,
    input  logic        if_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [3:0]  flush,
    output logic        busy,
    output logic [15:0] exc_count
);

    state_t      state_q, state_d;
    logic [31:0] target_q;
    logic [3:0]  mask_q;
    logic [2:0]  cnt_q;
    logic        start_exc, start_eret;

    // Exception wins over a simultaneous ERET.
    assign start_exc  = (state_q == IDLE) && (exc != EXC_NONE);
    assign start_eret = (state_q == IDLE) && (exc == EXC_NONE) && back;

    always_comb begin
        state_d        = state_q;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush          = '0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_exc || start_eret)
                    state_d = FLUSH;
            end
            FLUSH: begin
                flush = mask_q;
                if (cnt_q == 3'd1)
                    state_d = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                if (if_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_exc) begin
                target_q <= VECTOR;
                mask_q   <= FLUSH_MASK_EXC;
                cnt_q    <= 3'(FLUSH_CYCLES);
            end else if (start_eret) begin
                target_q <= epc;
                mask_q   <= FLUSH_MASK_ERET;
                cnt_q    <= 3'(FLUSH_CYCLES);
            end else if (state_q == FLUSH) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

`ifdef EXC_REDIRECT_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else if (start_exc && (count_q != '1))
            count_q <= count_q + 16'd1;
    end

    assign exc_count = count_q;
`else
    assign exc_count = '0;
`endif

endmodule

// File: tb/tb_exc_redirect.sv
// Directed table-driven bench for exc_redirect (default parameters).
module tb_exc_redirect;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  exc = '0;
    logic        back = 1'b0;
    logic [31:0] epc = '0;
    logic        if_ready = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  flush;
    logic        busy;
    logic [15:0] exc_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

`ifdef EXC_REDIRECT_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    exc_redirect #(.VECTOR(32'hBFC00380), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .exc(exc), .back(back), .epc(epc),
        .if_ready(if_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
        .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  exc;
        logic        back;
        logic [31:0] epc;
        logic        rdy;
        logic        rv;
        logic [31:0] pc;
        logic [3:0]  fl;
        logic        busy;
        int unsigned cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] e, input logic b, input logic [31:0] p, input logic r,
                       input logic rv, input logic [31:0] pc, input logic [3:0] fl,
                       input logic bz, input int unsigned cnt);
        vec_t v;
        v.exc = e; v.back = b; v.epc = p; v.rdy = r;
        v.rv = rv; v.pc = pc; v.fl = fl; v.busy = bz; v.cnt = CNT_ON ? cnt : 0;
        vecs.push_back(v);
    endtask

    // Drive inputs after the falling edge, check #1 after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        exc = v.exc; back = v.back; epc = v.epc; if_ready = v.rdy;
        @(posedge clk);
        #1;
        check({tag, ".rv"},    32'(redirect_valid), 32'(v.rv));
        check({tag, ".pc"},    redirect_pc,          v.pc);
        check({tag, ".flush"}, 32'(flush),           32'(v.fl));
        check({tag, ".busy"},  32'(busy),            32'(v.busy));
        check({tag, ".count"}, 32'(exc_count),       32'(v.cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rv"},    32'(redirect_valid), 32'd0);
        check({tag, ".pc"},    redirect_pc,          32'd0);
        check({tag, ".flush"}, 32'(flush),           32'd0);
        check({tag, ".busy"},  32'(busy),            32'd0);
        check({tag, ".count"}, 32'(exc_count),       32'd0);
    endtask

    localparam logic [31:0] V = 32'hBFC00380;

    initial begin
        // Basic exception, if_ready high.
        add(2'd1, 0, '0, 1,  0, '0, 4'hF, 1, 1);
        add(2'd0, 0, '0, 1,  0, '0, 4'hF, 1, 1);
        add(2'd0, 0, '0, 1,  1, V,  4'h0, 1, 1);
        add(2'd0, 0, '0, 1,  0, '0, 4'h0, 0, 1);
        // ERET with fetch stalled; back/exc during FLUSH/REDIRECT ignored.
        add(2'd0, 1, 32'h80001234, 0,  0, '0, 4'h3, 1, 1);
        add(2'd0, 1, 32'h0,        0,  0, '0, 4'h3, 1, 1);
        add(2'd1, 0, 32'h0,        0,  1, 32'h80001234, 4'h0, 1, 1);
        add(2'd0, 0, 32'h0,        0,  1, 32'h80001234, 4'h0, 1, 1);
        add(2'd1, 1, 32'h0,        0,  1, 32'h80001234, 4'h0, 1, 1);
        add(2'd0, 0, 32'h0,        0,  1, 32'h80001234, 4'h0, 1, 1);
        add(2'd0, 0, 32'h0,        0,  1, 32'h80001234, 4'h0, 1, 1);
        add(2'd0, 0, 32'h0,        1,  0, '0, 4'h0, 0, 1);
        // Delay-slot exception together with ERET: exception wins.
        add(2'd2, 1, 32'h12345678, 0,  0, '0, 4'hF, 1, 2);
        add(2'd0, 0, 32'h0,        1,  0, '0, 4'hF, 1, 2);
        add(2'd0, 0, 32'h0,        1,  1, V,  4'h0, 1, 2);
        // exc on the handshake cycle is not accepted.
        add(2'd1, 0, 32'h0,        1,  0, '0, 4'h0, 0, 2);
        // Misaligned EPC passes through.
        add(2'd0, 1, 32'h80000003, 1,  0, '0, 4'h3, 1, 2);
        add(2'd0, 0, 32'h0,        1,  0, '0, 4'h3, 1, 2);
        add(2'd0, 0, 32'h0,        1,  1, 32'h80000003, 4'h0, 1, 2);
        add(2'd0, 0, 32'h0,        1,  0, '0, 4'h0, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Reset in the second FLUSH cycle.
        @(negedge clk);
        exc = 2'd1; if_ready = 1'b1;
        @(negedge clk);
        exc = 2'd0;
        @(posedge clk);
        #2;
        check("midflush.flush_pre", 32'(flush), 32'hF);
        rst = 1'b1;
        #1;
        check_all_zero("midflush_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("post_rst_idle");
        for (int unsigned i = 0; i < 4; i++) begin
            vec_t v = vecs[i];
            apply(v, $sformatf("again%0d", i));
        end

`ifdef EXC_REDIRECT_COUNT_EN
        @(negedge clk);
        dut.count_q = 16'hFFFE;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                vec_t v = vecs[i];
                v.cnt = 32'hFFFF;
                apply(v, $sformatf("sat%0d_%0d", k, i));
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/exc_redirect.md
EXC_REDIRECT -- requirements
Module: exc_redirect

Interface
REQ-001 The block SHALL take parameter VECTOR, default 32'hBFC00380, as the exception entry PC.
REQ-002 The block SHALL take parameter FLUSH_CYCLES, default 2, range 1..7, as the number of cycles flush is held.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 exc  input  2  exception request from CP0: 0 none, 1 exception, 2 exception in delay slot.
REQ-006 back  input  1  ERET executing in stage 2.
REQ-007 epc  input  32  EPC value from CP0.
REQ-008 if_ready  input  1  fetch stage accepts a redirect this cycle.
REQ-009 redirect_valid  output  1  redirect_pc is valid.
REQ-010 redirect_pc  output  32  target PC for fetch.
REQ-011 flush  output  4  per-stage flush, {mem,ex,id,if}.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 exc_count  output  16  count of accepted exceptions.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, FLUSH and REDIRECT.
REQ-015 In IDLE with exc!=0, the block SHALL latch target=VECTOR and flush mask=4'b1111, then go to FLUSH.
REQ-016 In IDLE with exc==0 and back=1, the block SHALL latch target=epc and flush mask=4'b0011, then go to FLUSH.
REQ-017 If exc and back are active in the same cycle, the block SHALL treat it as an exception; the ERET is dropped.
REQ-018 In FLUSH, flush SHALL equal the latched mask for exactly FLUSH_CYCLES cycles; a 3-bit down-counter tracks this, then the FSM goes to REDIRECT.
REQ-019 flush SHALL be 0 in IDLE and in REDIRECT.
REQ-020 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc SHALL hold the target stable until redirect_valid and if_ready are both high; on that cycle the FSM returns to IDLE.
REQ-021 Latency: for a request sampled at edge N, flush SHALL rise after edge N and redirect_valid SHALL rise after edge N+FLUSH_CYCLES.
REQ-022 exc and back SHALL be ignored outside IDLE, since CP0 EXL blocks nesting.
REQ-023 redirect_pc SHALL be 0 whenever redirect_valid is 0.
REQ-024 epc SHALL be passed through unmodified, including misaligned values; CP0 raises the fetch error.
REQ-025 An accepted request SHALL return the FSM to IDLE on the handshake cycle and SHALL NOT be accepted again until the following cycle.

Reset
REQ-026 rst SHALL force the state to IDLE immediately, including mid-FLUSH or mid-REDIRECT, with no redirect issued.
REQ-027 While rst is high, redirect_valid=0, redirect_pc=0, flush=0, busy=0 and exc_count=0; the latched target, mask and counter SHALL also be 0.

Configuration
REQ-028 With macro EXC_REDIRECT_COUNT_EN defined, exc_count SHALL increment by 1 on each IDLE->FLUSH transition caused by exc (not by back) and saturate at 16'hFFFF.
REQ-029 Without EXC_REDIRECT_COUNT_EN, exc_count SHALL be constant 0 and no counter flops SHALL be generated.

Structure
REQ-030 A shared package SHALL hold: the state enum; exception code constants (EXC_NONE=0, EXC_NORM=1, EXC_DSLOT=2); flush bit indices (IF=0, ID=1, EX=2, MEM=3); and the default vector constant.
REQ-031 The block SHALL be a single module with no sub-module; the flush counter is inline.

Verification
REQ-032 exc=1 for one cycle, if_ready=1 -> flush=4'hF for 2 cycles, then redirect_valid=1 with redirect_pc=32'hBFC00380 for 1 cycle, busy high for 3 cycles.
REQ-033 back=1, epc=32'h80001234, if_ready=0 for 4 cycles then 1 -> flush=4'h3 for 2 cycles; redirect_pc=32'h80001234 held 5 cycles; back to IDLE after the handshake.
REQ-034 exc=2 and back=1 in the same cycle -> redirect_pc=32'hBFC00380, flush=4'hF, exc_count+1.
REQ-035 rst pulse during the second FLUSH cycle -> all outputs 0 immediately; a later exc=1 gives the full sequence again.
REQ-036 With EXC_REDIRECT_COUNT_EN, exc_count preloaded to 16'hFFFE, then 3 exceptions -> count reads 16'hFFFF; without the macro, exc_count stays 0.
REQ-037 exc=1 asserted during REDIRECT -> ignored: no extra flush, exc_count unchanged.
